// File: rtl/combo_code_writer_if.sv
// combo_code_writer_if: switch/key inputs and committed-combination outputs
// of the combination programming front-end.
//   master: drives prog/enter/abort/digit (debounced inputs side)
//   slave : the programming block itself
interface combo_code_writer_if #(
  parameter int DIGITS = 6
);
  logic                  prog;
  logic                  enter;
  logic                  abort;
  logic [3:0]            digit;
  logic [4*DIGITS-1:0]   code;
  logic                  code_update;
  logic                  busy;
  logic [1:0]            status;
  logic [3:0]            count;
  logic                  bad_digit;

  modport master (
    output prog, enter, abort, digit,
    input  code, code_update, busy, status, count, bad_digit
  );

  modport slave (
    input  prog, enter, abort, digit,
    output code, code_update, busy, status, count, bad_digit
  );
endinterface

// File: rtl/combo_code_writer.sv
// combo_code_writer: programs the stored combination of the board lock.
// Digits are entered one per enter key rising edge into a shadow register
// and committed to `code` after the last digit. With PROG_CONFIRM_EN
// defined, a second identical pass (CONFIRM) is required before commit and
// a mismatching pass lands in ERROR; without it, the last ENTRY digit
// commits directly. Reset is synchronous, active-high.
module combo_code_writer #(
  parameter int                  DIGITS       = 6,
  parameter logic [4*DIGITS-1:0] DEFAULT_CODE = 24'h838482
) (
  input  logic                 clk,
  input  logic                 reset,
  combo_code_writer_if.slave   bus
);

  localparam int         IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [3:0] LAST = 4'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ENTRY   = 2'b01,
    S_CONFIRM = 2'b10,
    S_ERROR   = 2'b11
  } state_t;

  state_t                      state_q, state_d;
  logic                        prog_q, enter_q;
  logic [3:0]                  count_q, count_d;
  logic [DIGITS-1:0][3:0]      shadow_q, shadow_d;
  logic [4*DIGITS-1:0]         code_q, code_d;
  logic                        code_update_q, code_update_d;
  logic                        bad_digit_q, bad_digit_d;
  logic                        busy_q, busy_d;
`ifdef PROG_CONFIRM_EN
  logic                        mismatch_q, mismatch_d;
  logic                        mm;
`endif

  logic          prog_rise, enter_rise, digit_ok;
  logic [IW-1:0] nib;

  assign prog_rise  = bus.prog  & ~prog_q;
  assign enter_rise = bus.enter & ~enter_q;
  assign digit_ok   = (bus.digit <= 4'd9);
  // First digit sits in the most-significant nibble.
  assign nib        = IW'(DIGITS - 1) - IW'(count_q);

  // Next-state, counter, shadow and commit logic; abort > prog_rise > enter_rise.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d       = state_q;
    count_d       = count_q;
    shadow_d      = shadow_q;
    code_d        = code_q;
    code_update_d = 1'b0;
    bad_digit_d   = 1'b0;
`ifdef PROG_CONFIRM_EN
    mismatch_d    = mismatch_q;
    mm            = mismatch_q | (shadow_q[nib] != bus.digit);
`endif

    if (bus.abort) begin
      state_d = S_IDLE;
      count_d = 4'd0;
    end else if (prog_rise) begin
      state_d = S_ENTRY;
      count_d = 4'd0;
    end else if (enter_rise && (state_q == S_ENTRY || state_q == S_CONFIRM)) begin
      if (!digit_ok) begin
        bad_digit_d = 1'b1;
      end else if (state_q == S_ENTRY) begin
        shadow_d[nib] = bus.digit;
        count_d       = count_q + 4'd1;
        if (count_q == LAST) begin
          count_d = 4'd0;
`ifdef PROG_CONFIRM_EN
          state_d    = S_CONFIRM;
          mismatch_d = 1'b0;
`else
          state_d       = S_IDLE;
          code_d        = shadow_d;
          code_update_d = 1'b1;
`endif
        end
      end
`ifdef PROG_CONFIRM_EN
      else begin
        mismatch_d = mm;
        count_d    = count_q + 4'd1;
        if (count_q == LAST) begin
          count_d = 4'd0;
          if (!mm) begin
            state_d       = S_IDLE;
            code_d        = shadow_q;
            code_update_d = 1'b1;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
`endif
    end

    busy_d = (state_d == S_ENTRY) || (state_d == S_CONFIRM);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q       <= S_IDLE;
      prog_q        <= 1'b0;
      enter_q       <= 1'b0;
      count_q       <= 4'd0;
      code_q        <= DEFAULT_CODE;
      code_update_q <= 1'b0;
      bad_digit_q   <= 1'b0;
      busy_q        <= 1'b0;
`ifdef PROG_CONFIRM_EN
      mismatch_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      prog_q        <= bus.prog;
      enter_q       <= bus.enter;
      count_q       <= count_d;
      code_q        <= code_d;
      code_update_q <= code_update_d;
      bad_digit_q   <= bad_digit_d;
      busy_q        <= busy_d;
`ifdef PROG_CONFIRM_EN
      mismatch_q    <= mismatch_d;
`endif
    end
  end

  // Shadow digits; always written before being read in a session.
  always_ff @(posedge clk) begin
    // NOTE: the shadow is deliberately not reset; its contents are don't-care
    // until a full ENTRY pass has filled it.
    shadow_q <= shadow_d;
  end

  assign bus.code        = code_q;
  assign bus.code_update = code_update_q;
  assign bus.busy        = busy_q;
  assign bus.status      = state_q;
  assign bus.count       = count_q;
  assign bus.bad_digit   = bad_digit_q;

endmodule

// File: tb/tb_combo_code_writer.sv
// tb_combo_code_writer: directed bench for combo_code_writer (DIGITS=6).
// Expectations follow PROG_CONFIRM_EN the same way the design does.
module tb_combo_code_writer;

  localparam logic [23:0] DEF = 24'h838482;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   pulses = 0;
  logic [23:0] exp_code;

  combo_code_writer_if #(.DIGITS(6)) bus ();

  combo_code_writer #(.DIGITS(6), .DEFAULT_CODE(DEF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Counts code_update pulses, sampled on the inactive edge.
  always @(negedge clk) if (bus.code_update === 1'b1) pulses++;

  // One low cycle (clears enter_q), then one enter-high cycle.
  task automatic press(input logic [3:0] d);
    @(negedge clk);
    bus.digit = d;
    bus.enter = 1'b1;
    @(negedge clk);
    bus.enter = 1'b0;
  endtask

  task automatic do_prog();
    @(negedge clk);
    bus.prog = 1'b1;
    @(negedge clk);
    bus.prog = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tests++; if (bus.code !== DEF) begin $display("FAIL reset_code: got %h want %h", bus.code, DEF); fails++; end
    tests++; if (bus.status !== 2'b00) begin $display("FAIL reset_status: got %b want 00", bus.status); fails++; end
    tests++; if (bus.count !== 4'd0) begin $display("FAIL reset_count: got %0d want 0", bus.count); fails++; end
    tests++; if ({bus.busy, bus.code_update, bus.bad_digit} !== 3'b000) begin
      $display("FAIL reset_pulses: got %b want 000", {bus.busy, bus.code_update, bus.bad_digit}); fails++; end
    exp_code = DEF;
  endtask

  task automatic test_idle_ignores_enter();
    press(4'd5);
    tests++; if (bus.status !== 2'b00 || bus.count !== 4'd0) begin
      $display("FAIL idle_enter: got status %b count %0d want 00/0", bus.status, bus.count); fails++; end
    press(4'hA);
    tests++; if (bus.bad_digit !== 1'b0) begin $display("FAIL idle_bad_digit: got %b want 0", bus.bad_digit); fails++; end
  endtask

  task automatic test_entry_bad_digit_hold();
    do_prog();
    tests++; if (bus.status !== 2'b01 || bus.count !== 4'd0 || bus.busy !== 1'b1) begin
      $display("FAIL prog_start: got status %b count %0d busy %b want 01/0/1", bus.status, bus.count, bus.busy); fails++; end
    press(4'd1);
    tests++; if (bus.count !== 4'd1) begin $display("FAIL entry_count1: got %0d want 1", bus.count); fails++; end
    press(4'hA);
    tests++; if (bus.bad_digit !== 1'b1 || bus.count !== 4'd1) begin
      $display("FAIL bad_digit: got pulse %b count %0d want 1/1", bus.bad_digit, bus.count); fails++; end
    @(negedge clk);
    tests++; if (bus.bad_digit !== 1'b0) begin $display("FAIL bad_digit_fall: got %b want 0", bus.bad_digit); fails++; end
    press(4'd9);
    tests++; if (bus.count !== 4'd2 || bus.bad_digit !== 1'b0) begin
      $display("FAIL digit9: got count %0d bad %b want 2/0", bus.count, bus.bad_digit); fails++; end
    @(negedge clk);
    bus.digit = 4'd3;
    bus.enter = 1'b1;
    repeat (10) @(negedge clk);
    tests++; if (bus.count !== 4'd3) begin $display("FAIL hold_enter: got count %0d want 3", bus.count); fails++; end
    bus.enter = 1'b0;
  endtask

  // Abort with a simultaneous enter rise and prog rise after 3 digits.
  task automatic test_abort();
    @(negedge clk);
    bus.digit = 4'd5;
    bus.enter = 1'b1;
    bus.prog  = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    tests++; if (bus.status !== 2'b00 || bus.count !== 4'd0 || bus.busy !== 1'b0) begin
      $display("FAIL abort: got status %b count %0d busy %b want 00/0/0", bus.status, bus.count, bus.busy); fails++; end
    tests++; if (bus.code !== exp_code) begin $display("FAIL abort_code: got %h want %h", bus.code, exp_code); fails++; end
    bus.abort = 1'b0;
    bus.enter = 1'b0;
    bus.prog  = 1'b0;
    @(negedge clk);
  endtask

`ifdef PROG_CONFIRM_EN
  task automatic test_confirm_commit();
    logic [3:0] seq [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    do_prog();
    foreach (seq[i]) press(seq[i]);
    tests++; if (bus.status !== 2'b10 || bus.count !== 4'd0 || bus.busy !== 1'b1) begin
      $display("FAIL to_confirm: got status %b count %0d busy %b want 10/0/1", bus.status, bus.count, bus.busy); fails++; end
    pulses = 0;
    for (int i = 0; i < 5; i++) press(seq[i]);
    tests++; if (bus.code !== exp_code || bus.count !== 4'd5) begin
      $display("FAIL confirm_partial: got code %h count %0d want %h/5", bus.code, bus.count, exp_code); fails++; end
    press(seq[5]);
    exp_code = 24'h123456;
    tests++; if (bus.code !== exp_code || bus.code_update !== 1'b1) begin
      $display("FAIL commit: got code %h upd %b want %h/1", bus.code, bus.code_update, exp_code); fails++; end
    tests++; if (bus.status !== 2'b00 || bus.busy !== 1'b0) begin
      $display("FAIL commit_status: got %b busy %b want 00/0", bus.status, bus.busy); fails++; end
    repeat (2) @(negedge clk);
    tests++; if (bus.code_update !== 1'b0 || pulses !== 1) begin
      $display("FAIL commit_pulse: got upd %b pulses %0d want 0/1", bus.code_update, pulses); fails++; end
  endtask

  task automatic test_mismatch_error();
    logic [3:0] a [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    logic [3:0] b [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7};
    logic [3:0] c [6] = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd0, 4'd1};
    do_prog();
    foreach (a[i]) press(a[i]);
    foreach (b[i]) press(b[i]);
    tests++; if (bus.status !== 2'b11 || bus.code !== exp_code || bus.code_update !== 1'b0) begin
      $display("FAIL mismatch: got status %b code %h upd %b want 11/%h/0", bus.status, bus.code, bus.code_update, exp_code); fails++; end
    repeat (3) @(negedge clk);
    tests++; if (bus.status !== 2'b11 || bus.busy !== 1'b0) begin
      $display("FAIL error_hold: got status %b busy %b want 11/0", bus.status, bus.busy); fails++; end
    do_prog();
    tests++; if (bus.status !== 2'b01 || bus.count !== 4'd0) begin
      $display("FAIL error_reprog: got status %b count %0d want 01/0", bus.status, bus.count); fails++; end
    // A rejected digit in CONFIRM must not poison the comparison.
    foreach (c[i]) press(c[i]);
    press(c[0]);
    press(4'hB);
    tests++; if (bus.bad_digit !== 1'b1 || bus.count !== 4'd1 || bus.status !== 2'b10) begin
      $display("FAIL confirm_bad: got bad %b count %0d status %b want 1/1/10", bus.bad_digit, bus.count, bus.status); fails++; end
    for (int i = 1; i < 6; i++) press(c[i]);
    exp_code = 24'h246801;
    tests++; if (bus.code !== exp_code || bus.status !== 2'b00) begin
      $display("FAIL confirm_bad_commit: got code %h status %b want %h/00", bus.code, bus.status, exp_code); fails++; end
  endtask

  task automatic test_reset_mid();
    do_prog();
    for (int i = 1; i <= 6; i++) press(4'(i));
    press(4'd1);
    press(4'd2);
    tests++; if (bus.status !== 2'b10 || bus.count !== 4'd2) begin
      $display("FAIL pre_reset: got status %b count %0d want 10/2", bus.status, bus.count); fails++; end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_code = DEF;
    tests++; if (bus.code !== DEF || bus.status !== 2'b00 || bus.count !== 4'd0) begin
      $display("FAIL reset_mid: got code %h status %b count %0d want %h/00/0", bus.code, bus.status, bus.count, DEF); fails++; end
  endtask
`else
  task automatic test_direct_commit();
    logic [3:0] seq [6] = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4};
    do_prog();
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      press(seq[i]);
      if (i == 2) press(4'hF);
    end
    tests++; if (bus.code !== exp_code || bus.count !== 4'd5 || bus.status !== 2'b01) begin
      $display("FAIL direct_partial: got code %h count %0d status %b want %h/5/01", bus.code, bus.count, bus.status, exp_code); fails++; end
    press(seq[5]);
    exp_code = 24'h987654;
    tests++; if (bus.code !== exp_code || bus.code_update !== 1'b1) begin
      $display("FAIL direct_commit: got code %h upd %b want %h/1", bus.code, bus.code_update, exp_code); fails++; end
    tests++; if (bus.status !== 2'b00 || bus.busy !== 1'b0) begin
      $display("FAIL direct_status: got %b busy %b want 00/0", bus.status, bus.busy); fails++; end
    repeat (2) @(negedge clk);
    tests++; if (bus.code_update !== 1'b0 || pulses !== 1) begin
      $display("FAIL direct_pulse: got upd %b pulses %0d want 0/1", bus.code_update, pulses); fails++; end
    // Second session with a different code.
    do_prog();
    for (int i = 0; i < 6; i++) press(4'(i));
    exp_code = 24'h012345;
    tests++; if (bus.code !== exp_code) begin $display("FAIL direct_second: got %h want %h", bus.code, exp_code); fails++; end
  endtask

  task automatic test_reset_mid();
    do_prog();
    press(4'd1);
    press(4'd2);
    press(4'd3);
    tests++; if (bus.status !== 2'b01 || bus.count !== 4'd3) begin
      $display("FAIL pre_reset: got status %b count %0d want 01/3", bus.status, bus.count); fails++; end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_code = DEF;
    tests++; if (bus.code !== DEF || bus.status !== 2'b00 || bus.count !== 4'd0) begin
      $display("FAIL reset_mid: got code %h status %b count %0d want %h/00/0", bus.code, bus.status, bus.count, DEF); fails++; end
  endtask
`endif

  // A prog level already high at reset release counts as a rising edge.
  task automatic test_prog_at_reset();
    @(negedge clk);
    reset    = 1'b1;
    bus.prog = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (bus.status !== 2'b00) begin $display("FAIL prog_in_reset: got %b want 00", bus.status); fails++; end
    reset = 1'b0;
    @(negedge clk);
    tests++; if (bus.status !== 2'b01 || bus.busy !== 1'b1) begin
      $display("FAIL prog_at_release: got status %b busy %b want 01/1", bus.status, bus.busy); fails++; end
    bus.prog  = 1'b0;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    tests++; if (bus.status !== 2'b00 || bus.code !== DEF) begin
      $display("FAIL final_abort: got status %b code %h want 00/%h", bus.status, bus.code, DEF); fails++; end
  endtask

  initial begin
    reset     = 1'b1;
    bus.prog  = 1'b0;
    bus.enter = 1'b0;
    bus.abort = 1'b0;
    bus.digit = 4'd0;
    test_reset();
    test_idle_ignores_enter();
    test_entry_bad_digit_hold();
    test_abort();
`ifdef PROG_CONFIRM_EN
    test_confirm_commit();
    test_mismatch_error();
`else
    test_direct_commit();
`endif
    test_reset_mid();
    test_prog_at_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/combo_code_writer.md
# combo_code_writer

Programming front-end for the board's combination lock. Lets the user enter a new DIGITS-long decimal combination on the switches, one digit per key press, optionally confirm it with a second identical pass, then commits it to the stored-combination register. The lock reads that register. The block sits between the debounced switch/key inputs and the lock FSM and owns the only copy of the combination.

## Interface

Parameters:
- DIGITS, default 6: combination length, legal range 1..8.
- DEFAULT_CODE, default 24'h838482: combination loaded on reset, 4*DIGITS bits, first digit in the most-significant nibble.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high.
- prog, input, 1: level; a rising edge starts or restarts a programming session.
- enter, input, 1: level; a rising edge offers `digit` for acceptance.
- abort, input, 1: level; while high, forces the FSM to IDLE.
- digit, input, 4: BCD digit candidate.
- code, output, 4*DIGITS: committed combination; first digit in the MS nibble.
- code_update, output, 1: one-cycle pulse in the cycle `code` takes a new value.
- busy, output, 1: high in ENTRY and CONFIRM.
- status, output, 2: 00 IDLE, 01 ENTRY, 10 CONFIRM, 11 ERROR.
- count, output, 4: digits accepted in the current pass.
- bad_digit, output, 1: one-cycle pulse when an offered digit is rejected.

## Operation

- Edge detect: registers `prog_q` and `enter_q` hold the previous-cycle levels.
  - prog_rise = prog & ~prog_q.
  - enter_rise = enter & ~enter_q.
- States:
  - IDLE: prog_rise → ENTRY, count=0. enter_rise is ignored.
  - ENTRY: enter_rise with digit≤9 → digit written to shadow nibble `count`, count+1.
    - On the DIGITS-th digit → CONFIRM, count=0, mismatch=0.
  - CONFIRM: enter_rise with digit≤9 → compare against shadow nibble `count`; set sticky `mismatch` on inequality; count+1.
    - On the DIGITS-th digit, if no mismatch (including this digit): code←shadow, code_update=1, → IDLE.
    - Otherwise → ERROR.
  - ERROR: holds until prog_rise (→ ENTRY, count=0) or abort (→ IDLE).
- Digit rejection: digit>9 on enter_rise in ENTRY or CONFIRM.
  - Digit not accepted, count unchanged, bad_digit pulses.
  - A rejected digit does not set `mismatch`.
- Priority, highest first: abort, then prog_rise, then enter_rise.
  - abort in any state → IDLE, count=0; `code` unchanged.
  - prog_rise in ENTRY, CONFIRM or ERROR → ENTRY, count=0; shadow contents are don't-care.
- Shadow register: 4*DIGITS bits, internal, never visible on `code` before commit.

## Timing

- Reset values:
  - code=DEFAULT_CODE, state IDLE, status=00.
  - count=0, busy=0, code_update=0, bad_digit=0.
  - prog_q=0 and enter_q=0; a level already high at reset release therefore counts as an edge.
- All outputs are registered.
- Latency: enter_rise sampled at clock edge T; count, status and bad_digit reflect it after edge T.
- Commit: on the final CONFIRM digit, code and code_update change at the same edge T. code_update falls at T+1.
- enter held high for many cycles accepts exactly one digit.
- One digit per enter_rise; back-to-back rises every 2 cycles are legal.
- Reset mid-session discards the partial entry and restores DEFAULT_CODE.

## Configuration

- PROG_CONFIRM_EN defined: two-pass flow as above; CONFIRM and ERROR are reachable.
- PROG_CONFIRM_EN undefined:
  - The DIGITS-th digit accepted in ENTRY commits the shadow directly (code update, code_update pulse, → IDLE at that edge).
  - CONFIRM and ERROR are not built; status never shows 10 or 11.

## Test plan

- Reset → code=24'h838482, status=00, count=0, all pulses low.
- Confirm enabled: prog; enter 1,2,3,4,5,6; enter 1,2,3,4,5,6 → code=24'h123456, single code_update pulse, status=00.
- Confirm enabled: entry 1..6, confirm 1,2,3,4,5,7 → status=11, code unchanged. Then prog → status=01, count=0.
- Entry: enter with digit=4'hA → bad_digit pulse, count unchanged. Then digit 9 → count+1. Also hold enter high 10 cycles → count increments once.
- Abort after 3 entry digits, and abort asserted in the same cycle as enter_rise → status=00, count=0, code unchanged. Reset mid-CONFIRM → DEFAULT_CODE restored.
- Confirm disabled: prog; enter 9,8,7,6,5,4 → code=24'h987654 at the 6th digit's edge.
